fetch_queue: RTL and testbench

//  Instruction fetch stage feeding the decode/execute datapath. Owns the fetch PC
//  and issues word reads to instruction memory over a req/ack handshake
//  (variable latency). Buffers returned words with their PC in a prefetch FIFO and

---
 rtl/fetch_queue.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage. Owns the fetch PC, issues one word
//             read at a time to instruction memory over a req/ack handshake
//             (variable latency), buffers returned words together with their
//             PC in a small prefetch FIFO and hands them downstream over a
//             valid/ready interface. A taken-branch redirect flushes the
//             queue and restarts fetching at the redirect target.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk          in   1           clock, all state updates on rising edge
//   rst          in   1           asynchronous reset, active low (0 = reset)
//   redirect     in   1           branch taken: flush, refetch from redirect_pc
//   redirect_pc  in   DATA_WIDTH  new fetch address (bits [1:0] forced to 0)
//   mem_req      out  1           read request to instruction memory
//   mem_addr     out  DATA_WIDTH  word address of request, stable while mem_req
//   mem_ack      in   1           memory returns mem_rdata this cycle
//   mem_rdata    in   DATA_WIDTH  fetched instruction word
//   instr_valid  out  1           FIFO head holds a valid instruction
//   instr_ready  in   1           downstream consumes the head this cycle
//   instr        out  DATA_WIDTH  instruction at FIFO head
//   instr_pc     out  DATA_WIDTH  PC of the instruction at FIFO head
// ============================================================================
module fetch_queue #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int                 c_ptr_w = $clog2(DEPTH);
   localparam int                 c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_pinc  = c_ptr_w'(1);
   localparam logic [DATA_WIDTH-1:0] c_word_step = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] c_align_mask = ~(DATA_WIDTH'(3));

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,   // no request outstanding
      ST_WAIT    = 2'd1,   // request outstanding, data will be kept
      ST_DISCARD = 2'd2    // request outstanding, data will be dropped
   } state_t;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t                 state_q,    state_d;
   logic [DATA_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0]  addr_q,     addr_d;

   logic [DATA_WIDTH-1:0]  data_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]  pc_mem_q   [DEPTH];
   logic [c_ptr_w-1:0]     wr_ptr_q;
   logic [c_ptr_w-1:0]     rd_ptr_q;
   logic [c_cnt_w-1:0]     count_q;

   // -------------------------------------------------------------------------
   // Datapath helpers
   // -------------------------------------------------------------------------
   logic                   w_push;
   logic                   w_pop;
   logic                   w_not_empty;
   logic [c_cnt_w-1:0]     w_count_after;
   logic [DATA_WIDTH-1:0]  w_target_pc;
   logic [DATA_WIDTH-1:0]  w_next_addr;

   assign w_not_empty = (count_q != '0);

   // A redirect flushes the queue on the same edge, so it suppresses both the
   // push of any returning word and the pop requested by downstream.
   assign w_push = (state_q == ST_WAIT) && mem_ack && !redirect;
   assign w_pop  = w_not_empty && instr_ready && !redirect;

   // Redirect targets are forced to word alignment.
   assign w_target_pc = redirect_pc & c_align_mask;

   // Sequential word address; wraps naturally modulo 2^DATA_WIDTH.
   assign w_next_addr = addr_q + c_word_step;

   // Occupancy after this edge's push and pop; used to decide whether a
   // back-to-back request can be issued without overflowing the FIFO.
   always_comb begin
      w_count_after = count_q;
      if (w_push && !w_pop) begin
         w_count_after = count_q + c_one;
      end else if (!w_push && w_pop) begin
         w_count_after = count_q - c_one;
      end
   end

   // -------------------------------------------------------------------------
   // Fetch FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   // -------------------------------------------------------------------------
   // Fetch FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;

      case (state_q)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_d = w_target_pc;
            end else if (count_q < c_depth) begin
               // Issue only when a FIFO slot is guaranteed for the result.
               state_d = ST_WAIT;
               addr_d  = fetch_pc_q;
            end
         end

         ST_WAIT: begin
            if (redirect) begin
               fetch_pc_d = w_target_pc;
               // An un-acked request cannot be withdrawn: wait it out and
               // throw its data away. If it completes now, just drop it.
               state_d = mem_ack ? ST_IDLE : ST_DISCARD;
            end else if (mem_ack) begin
               fetch_pc_d = w_next_addr;
               if (w_count_after < c_depth) begin
                  // Chain the next request with no idle cycle in between.
                  addr_d = w_next_addr;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_DISCARD: begin
            if (redirect) begin
               fetch_pc_d = w_target_pc;
            end
            if (mem_ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Prefetch FIFO
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else if (redirect) begin
         // Flush: the stored entries become unreachable, contents are kept.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            data_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= addr_q;
            wr_ptr_q             <= wr_ptr_q + c_pinc;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + c_pinc;
         end
         count_q <= w_count_after;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign mem_req     = (state_q == ST_WAIT) || (state_q == ST_DISCARD);
   assign mem_addr    = addr_q;
   assign instr_valid = w_not_empty;
   assign instr       = data_mem_q[rd_ptr_q];
   assign instr_pc    = pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. Directed scenarios for
//             reset, burst fill, drain, redirects and async reset, followed by
//             a randomised run checked against a reference PC model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue #(
      .DATA_WIDTH (32),
      .DEPTH      (4),
      .RESET_PC   (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Instruction memory contents as a function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      instr_ready = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, instr_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ctrl: req/valid=%b required 00", {mem_req, instr_valid});
      end
      n_checks++;
      if (mem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h required 00000000", mem_addr);
      end
      n_checks++;
      if ({instr, instr_pc} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_head: instr=%h pc=%h required 0", instr, instr_pc);
      end
      repeat (2) tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_release: req=%b addr=%h required 1/00000000", mem_req, mem_addr);
      end
   endtask

   task automatic test_burst();
      do_reset();
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({mem_req, mem_addr} !== {1'b1, 32'(4 * i)}) begin
            n_fail++;
            $display("FAIL burst_addr%0d: req=%b addr=%h required 1/%h", i, mem_req, mem_addr, 32'(4 * i));
         end
         mem_rdata = mem_word(mem_addr);
      end
      tick();
      n_checks++;
      if ({mem_req, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 32'h0, mem_word(32'h0)}) begin
         n_fail++;
         $display("FAIL burst_full: req=%b valid=%b pc=%h instr=%h required 0/1/00000000/%h",
                  mem_req, instr_valid, instr_pc, instr, mem_word(32'h0));
      end
      tick();
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_hold: req=%b required 0 while full", mem_req);
      end
   endtask

   // Continues from the full FIFO left by test_burst, ack still tied high.
   task automatic test_drain();
      logic [31:0] exp_pc;
      instr_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         exp_pc = 32'(4 * k);
         n_checks++;
         if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
            n_fail++;
            $display("FAIL drain_head%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                     k, instr_valid, instr_pc, instr, exp_pc, mem_word(exp_pc));
         end
         n_checks++;
         if (k < 2) begin
            if (mem_req !== 1'b0) begin
               n_fail++;
               $display("FAIL drain_req%0d: req=%b required 0", k, mem_req);
            end
         end else if ({mem_req, mem_addr} !== {1'b1, 32'(32'h10 + 4 * (k - 2))}) begin
            n_fail++;
            $display("FAIL drain_req%0d: req=%b addr=%h required 1/%h",
                     k, mem_req, mem_addr, 32'(32'h10 + 4 * (k - 2)));
         end
         mem_rdata = mem_word(mem_addr);
         tick();
      end
      instr_ready = 1'b0;
      mem_ack     = 1'b0;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      tick();
      n_checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL rdw_issue: req=%b addr=%h required 1/00000000", mem_req, mem_addr);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rdw_discard%0d: req=%b addr=%h valid=%b required 1/00000000/0",
                     i, mem_req, mem_addr, instr_valid);
         end
         if (i == 1) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_0000;
         end
         tick();
      end
      mem_ack = 1'b0;
      n_checks++;
      if ({mem_req, instr_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL rdw_idle: req/valid=%b required 00", {mem_req, instr_valid});
      end
      tick();
      n_checks++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL rdw_refetch: req=%b addr=%h valid=%b required 1/00000100/0",
                  mem_req, mem_addr, instr_valid);
      end
      mem_ack   = 1'b1;
      mem_rdata = mem_word(32'h100);
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
         n_fail++;
         $display("FAIL rdw_first: valid=%b pc=%h instr=%h required 1/00000100/%h",
                  instr_valid, instr_pc, instr, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_flush();
      do_reset();
      mem_ack = 1'b1;
      tick();
      mem_rdata = mem_word(mem_addr);
      tick();
      mem_rdata = mem_word(mem_addr);
      tick();
      n_checks++;
      if ({instr_valid, instr_pc, mem_req, mem_addr} !== {1'b1, 32'h0, 1'b1, 32'h8}) begin
         n_fail++;
         $display("FAIL rfl_pre: valid=%b pc=%h req=%b addr=%h required 1/00000000/1/00000008",
                  instr_valid, instr_pc, mem_req, mem_addr);
      end
      mem_rdata   = mem_word(mem_addr);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      instr_ready = 1'b1;
      tick();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      mem_ack     = 1'b0;
      n_checks++;
      if ({instr_valid, mem_req} !== 2'b00) begin
         n_fail++;
         $display("FAIL rfl_flush: valid/req=%b required 00", {instr_valid, mem_req});
      end
      tick();
      n_checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
         n_fail++;
         $display("FAIL rfl_refetch: req=%b addr=%h required 1/00000200", mem_req, mem_addr);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      mem_ack = 1'b1;
      tick();
      mem_rdata = mem_word(mem_addr);
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({mem_req, instr_valid, mem_addr} !== {1'b1, 1'b1, 32'h4}) begin
         n_fail++;
         $display("FAIL ares_pre: req=%b valid=%b addr=%h required 1/1/00000004",
                  mem_req, instr_valid, mem_addr);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, instr_valid, mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL ares_drop: req=%b valid=%b addr=%h required 0/0/00000000",
                  mem_req, instr_valid, mem_addr);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      n_checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL ares_restart: req=%b addr=%h required 1/00000000", mem_req, mem_addr);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] req_addr;
      logic [31:0] tgt;
      logic        pending;
      int          lat;
      int          wait_cnt;
      int          n_pops;
      do_reset();
      exp_pc   = 32'h0;
      req_addr = '0;
      pending  = 1'b0;
      lat      = 0;
      wait_cnt = 0;
      n_pops   = 0;
      for (int c = 0; c < 600; c++) begin
         tick();
         // Memory responder: one outstanding request, latency 0..5 cycles.
         mem_ack   = 1'b0;
         mem_rdata = 32'hDEAD_BEEF;
         if (pending) begin
            n_checks++;
            if ({mem_req, mem_addr} !== {1'b1, req_addr}) begin
               n_fail++;
               $display("FAIL rnd_hold c%0d: req=%b addr=%h required 1/%h", c, mem_req, mem_addr, req_addr);
            end
         end else if (mem_req) begin
            pending  = 1'b1;
            req_addr = mem_addr;
            lat      = int'($urandom_range(0, 5));
            wait_cnt = 0;
         end
         if (pending) begin
            if (wait_cnt == lat) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_word(req_addr);
               pending   = 1'b0;
            end else begin
               wait_cnt++;
            end
         end
         // Downstream and branch stimulus.
         redirect    = ($urandom_range(0, 19) == 0);
         instr_ready = ($urandom_range(0, 2) != 0);
         tgt         = 32'h1000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
         redirect_pc = tgt;
         if (instr_valid) begin
            n_checks++;
            if ({instr_pc, instr} !== {exp_pc, mem_word(exp_pc)}) begin
               n_fail++;
               $display("FAIL rnd_head c%0d: pc=%h instr=%h required %h/%h",
                        c, instr_pc, instr, exp_pc, mem_word(exp_pc));
            end
            if (instr_ready && !redirect) begin
               exp_pc = exp_pc + 32'h4;
               n_pops++;
            end
         end
         if (redirect) begin
            exp_pc = {tgt[31:2], 2'b00};
         end
      end
      redirect    = 1'b0;
      instr_ready = 1'b0;
      mem_ack     = 1'b0;
      n_checks++;
      if (n_pops < 50) begin
         n_fail++;
         $display("FAIL rnd_progress: pops=%0d required at least 50", n_pops);
      end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_drain();
      test_redirect_wait();
      test_redirect_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
